// File: rtl/instr_decode_reg.sv
// ----------------------------------------------------------------------------
// instr_decode_reg
//
// Instruction register and decode stage for the multicycle CPU controller.
// This block captures the fetched instruction word when the controller
// strobes ir_load, and registers a one-hot opcode vector. The controller
// samples that vector in its decode state. The block also holds the 4-bit
// condition-flag register that the controller reads as its condition vector.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   defined   : an illegal opcode (opc >= NUM_OPS) sets a sticky flag and
//               bumps a saturating 8-bit counter.
//   undefined : illegal and ill_count are tied low, and clr_illegal is ignored.
//
// Ports
//   clock        in   system clock, rising-edge active
//   reset        in   synchronous active-high reset
//   mem_data     in   fetched instruction word
//   ir_load      in   IR-write strobe
//   alu_flags    in   {N,Z,C,V} from the ALU
//   flag_load    in   flag-register write enable
//   clr_illegal  in   clears the sticky illegal flag and the counter
//   A_out        out  registered one-hot decode (all-zero for an illegal opcode)
//   A_vec_4bits  out  registered flags {N,Z,C,V}
//   ir_q         out  instruction register
//   rd, rs, rt   out  register fields ir_q[10:8], ir_q[7:5], ir_q[4:2]
//   imm_sx       out  ir_q[7:0] sign-extended to WORD_W
//   dec_valid    out  A_out reflects a loaded instruction
//   illegal      out  sticky illegal-opcode indicator
//   ill_count    out  saturating illegal-opcode count
// ----------------------------------------------------------------------------
module instr_decode_reg #(
    parameter int WORD_W  = 16,
    parameter int NUM_OPS = 23
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WORD_W-1:0]   mem_data,
    input  logic                ir_load,
    input  logic [3:0]          alu_flags,
    input  logic                flag_load,
    input  logic                clr_illegal,
    output logic [NUM_OPS-1:0]  A_out,
    output logic [3:0]          A_vec_4bits,
    output logic [WORD_W-1:0]   ir_q,
    output logic [2:0]          rd,
    output logic [2:0]          rs,
    output logic [2:0]          rt,
    output logic [WORD_W-1:0]   imm_sx,
    output logic                dec_valid,
    output logic                illegal,
    output logic [7:0]          ill_count
);

    logic [WORD_W-1:0]  instr_q, instr_d;
    logic [NUM_OPS-1:0] a_q, a_d;
    logic [3:0]         flags_q, flags_d;
    logic               valid_q, valid_d;

    logic [4:0]         opc;
    logic               opc_legal;

    // Decode is done on the incoming word, so A_out is ready in the same cycle
    // as ir_q. A single shifted bit keeps the vector strictly one-hot or zero.
    assign opc       = mem_data[WORD_W-1:WORD_W-5];
    assign opc_legal = (int'(opc) < NUM_OPS);

    always_comb begin
        instr_d = instr_q;
        a_d     = a_q;
        valid_d = valid_q;
        flags_d = flags_q;
        if (ir_load) begin
            instr_d = mem_data;
            valid_d = 1'b1;
            if (opc_legal) begin
                a_d = {{(NUM_OPS-1){1'b0}}, 1'b1} << opc;
            end else begin
                a_d = '0;
            end
        end
        if (flag_load) begin
            flags_d = alu_flags;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            instr_q <= '0;
            a_q     <= '0;
            valid_q <= 1'b0;
            flags_q <= '0;
        end else begin
            instr_q <= instr_d;
            a_q     <= a_d;
            valid_q <= valid_d;
            flags_q <= flags_d;
        end
    end

    assign ir_q        = instr_q;
    assign A_out       = a_q;
    assign dec_valid   = valid_q;
    assign A_vec_4bits = flags_q;

    assign rd     = instr_q[10:8];
    assign rs     = instr_q[7:5];
    assign rt     = instr_q[4:2];
    assign imm_sx = {{(WORD_W-8){instr_q[7]}}, instr_q[7:0]};

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic       ill_q, ill_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_base;
    logic       ill_load;

    assign ill_load = ir_load & ~opc_legal;

    // When an illegal load and a clear arrive together, the load wins. The
    // count restarts from zero, so it reads 1 after that edge.
    always_comb begin
        cnt_base = clr_illegal ? 8'd0 : cnt_q;
        cnt_d    = cnt_base;
        ill_d    = clr_illegal ? 1'b0 : ill_q;
        if (ill_load) begin
            ill_d = 1'b1;
            if (cnt_base != 8'hFF) begin
                cnt_d = cnt_base + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ill_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ill_q <= ill_d;
            cnt_q <= cnt_d;
        end
    end

    assign illegal   = ill_q;
    assign ill_count = cnt_q;
`else
    logic unused_clr_illegal;
    assign unused_clr_illegal = clr_illegal;
    assign illegal            = 1'b0;
    assign ill_count          = 8'd0;
`endif

endmodule

// File: tb/tb_instr_decode_reg.sv
module tb_instr_decode_reg;

    localparam int WORD_W  = 16;
    localparam int NUM_OPS = 23;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic                clock = 1'b0;
    logic                reset;
    logic [WORD_W-1:0]   mem_data;
    logic                ir_load;
    logic [3:0]          alu_flags;
    logic                flag_load;
    logic                clr_illegal;
    logic [NUM_OPS-1:0]  A_out;
    logic [3:0]          A_vec_4bits;
    logic [WORD_W-1:0]   ir_q;
    logic [2:0]          rd, rs, rt;
    logic [WORD_W-1:0]   imm_sx;
    logic                dec_valid;
    logic                illegal;
    logic [7:0]          ill_count;

    instr_decode_reg #(.WORD_W(WORD_W), .NUM_OPS(NUM_OPS)) dut (
        .clock(clock), .reset(reset), .mem_data(mem_data), .ir_load(ir_load),
        .alu_flags(alu_flags), .flag_load(flag_load), .clr_illegal(clr_illegal),
        .A_out(A_out), .A_vec_4bits(A_vec_4bits), .ir_q(ir_q),
        .rd(rd), .rs(rs), .rt(rt), .imm_sx(imm_sx),
        .dec_valid(dec_valid), .illegal(illegal), .ill_count(ill_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        string               tag;
        logic [NUM_OPS-1:0]  a;
        logic [3:0]          f;
        logic [WORD_W-1:0]   ir;
        logic [2:0]          rd;
        logic [2:0]          rs;
        logic [2:0]          rt;
        logic [WORD_W-1:0]   imm;
        logic                dv;
        logic                ill;
        logic [7:0]          cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, want);
        end
    endtask

    // Monitor: one expectation per clock, sampled 1 time unit after the edge.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".A_out"},       32'(A_out),       32'(e.a));
            chk({e.tag, ".A_vec_4bits"}, 32'(A_vec_4bits), 32'(e.f));
            chk({e.tag, ".ir_q"},        32'(ir_q),        32'(e.ir));
            chk({e.tag, ".rd"},          32'(rd),          32'(e.rd));
            chk({e.tag, ".rs"},          32'(rs),          32'(e.rs));
            chk({e.tag, ".rt"},          32'(rt),          32'(e.rt));
            chk({e.tag, ".imm_sx"},      32'(imm_sx),      32'(e.imm));
            chk({e.tag, ".dec_valid"},   32'(dec_valid),   32'(e.dv));
            chk({e.tag, ".illegal"},     32'(illegal),     32'(e.ill));
            chk({e.tag, ".ill_count"},   32'(ill_count),   32'(e.cnt));
        end
    end

    function automatic exp_t mk(input string tag, input logic [NUM_OPS-1:0] a,
                                input logic [3:0] f, input logic [15:0] ir,
                                input logic [2:0] erd, input logic [2:0] ers,
                                input logic [2:0] ert, input logic [15:0] imm,
                                input logic dv, input logic ill, input logic [7:0] cnt);
        exp_t e;
        e.tag = tag; e.a = a; e.f = f; e.ir = ir; e.rd = erd; e.rs = ers;
        e.rt = ert; e.imm = imm; e.dv = dv; e.ill = ill; e.cnt = cnt;
        return e;
    endfunction

    // Drive one cycle's inputs away from the active edge and queue what the
    // outputs must read after that edge.
    task automatic cyc(input logic rst, input logic ld, input logic [15:0] md,
                       input logic fld, input logic [3:0] fl, input logic clr,
                       input bit do_exp, input exp_t e);
        @(negedge clock);
        reset = rst; ir_load = ld; mem_data = md;
        flag_load = fld; alu_flags = fl; clr_illegal = clr;
        if (do_exp) exp_q.push_back(e);
    endtask

    localparam logic [NUM_OPS-1:0] B9  = 23'h000200;
    localparam logic [NUM_OPS-1:0] B18 = 23'h040000;
    localparam logic [NUM_OPS-1:0] B22 = 23'h400000;
    localparam logic [NUM_OPS-1:0] Z   = 23'h000000;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t z0;
        logic [7:0] c;
        z0 = mk("reset", Z, 4'h0, 16'h0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 8'd0);
        reset = 1'b1; ir_load = 1'b0; mem_data = '0; flag_load = 1'b0;
        alu_flags = '0; clr_illegal = 1'b0;

        // Reset dominates even with both loads driven.
        cyc(1, 1, 16'h4A5C, 1, 4'hF, 0, 1, z0);
        cyc(1, 1, 16'h4A5C, 1, 4'hF, 0, 1, z0);
        z0.tag = "idle";
        cyc(0, 0, 16'h4A5C, 0, 4'hF, 0, 1, z0);

        cyc(0, 1, 16'h4A5C, 0, 4'h0, 0, 1,
            mk("legal", B9, 4'h0, 16'h4A5C, 3'd2, 3'd2, 3'd7, 16'h005C, 1, 0, 8'd0));
        cyc(0, 0, 16'hFFFF, 0, 4'hA, 0, 1,
            mk("hold", B9, 4'h0, 16'h4A5C, 3'd2, 3'd2, 3'd7, 16'h005C, 1, 0, 8'd0));

        cyc(0, 1, 16'h90F0, 0, 4'h0, 0, 1,
            mk("b2b0", B18, 4'h0, 16'h90F0, 3'd0, 3'd7, 3'd4, 16'hFFF0, 1, 0, 8'd0));
        cyc(0, 1, 16'hB081, 0, 4'h0, 0, 1,
            mk("b2b1", B22, 4'h0, 16'hB081, 3'd0, 3'd4, 3'd0, 16'hFF81, 1, 0, 8'd0));

        cyc(0, 1, 16'h4A5C, 1, 4'b0100, 0, 1,
            mk("flags", B9, 4'b0100, 16'h4A5C, 3'd2, 3'd2, 3'd7, 16'h005C, 1, 0, 8'd0));
        cyc(0, 0, 16'h0000, 0, 4'b1011, 0, 1,
            mk("flhold", B9, 4'b0100, 16'h4A5C, 3'd2, 3'd2, 3'd7, 16'h005C, 1, 0, 8'd0));

        // Opcode 23 is the first illegal value.
        cyc(0, 1, 16'hB800, 0, 4'h0, 0, 1,
            mk("opc23", Z, 4'b0100, 16'hB800, 3'd0, 3'd0, 3'd0, 16'h0000, 1, TRAP, TRAP ? 8'd1 : 8'd0));
        cyc(0, 0, 16'h0000, 0, 4'h0, 1, 1,
            mk("clr0", Z, 4'b0100, 16'hB800, 3'd0, 3'd0, 3'd0, 16'h0000, 1, 0, 8'd0));

        cyc(0, 1, 16'hF800, 0, 4'h0, 0, 1,
            mk("ill1", Z, 4'b0100, 16'hF800, 3'd0, 3'd0, 3'd0, 16'h0000, 1, TRAP, TRAP ? 8'd1 : 8'd0));
        c = 8'd1;
        for (int i = 0; i < 300; i++) begin
            if (c != 8'hFF) c = c + 8'd1;
            cyc(0, 1, 16'hF800, 0, 4'h0, 0, 1,
                mk("illsat", Z, 4'b0100, 16'hF800, 3'd0, 3'd0, 3'd0, 16'h0000, 1, TRAP, TRAP ? c : 8'd0));
        end

        cyc(0, 1, 16'hF800, 0, 4'h0, 1, 1,
            mk("clr+ill", Z, 4'b0100, 16'hF800, 3'd0, 3'd0, 3'd0, 16'h0000, 1, TRAP, TRAP ? 8'd1 : 8'd0));
        cyc(0, 0, 16'hF800, 0, 4'h0, 1, 1,
            mk("clr", Z, 4'b0100, 16'hF800, 3'd0, 3'd0, 3'd0, 16'h0000, 1, 0, 8'd0));

        cyc(0, 1, 16'h90F0, 0, 4'h0, 0, 1,
            mk("pre_rst", B18, 4'b0100, 16'h90F0, 3'd0, 3'd7, 3'd4, 16'hFFF0, 1, 0, 8'd0));
        z0.tag = "midrst";
        cyc(1, 1, 16'h4A5C, 1, 4'hF, 0, 1, z0);
        cyc(0, 0, 16'h0000, 0, 4'h0, 0, 0, z0);
        cyc(0, 0, 16'h0000, 0, 4'h0, 0, 0, z0);
        cyc(0, 0, 16'h0000, 0, 4'h0, 0, 0, z0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
